// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_pkg
//  Description : Shared types, constants and the parity helper for the
//                parity generation stage and its 2-entry skid buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

   // Occupancy of the 2-entry skid buffer
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } buf_state_e;

   // Width of the delivered-word counter
   localparam int c_cnt_w = 16;

   // Widest payload the parity helper accepts; narrower payloads are
   // zero-extended, which leaves the XOR reduction unchanged.
   localparam int c_par_max_w = 1024;

   // Parity bit for a payload: XOR of all payload bits, flipped for odd
   // parity, and flipped once more when the word is to be corrupted.
   function automatic logic calc_parity(
      input logic [c_par_max_w-1:0] payload,
      input logic                   even_odd,
      input logic                   corrupt
   );
      return (^payload) ^ even_odd ^ corrupt;
   endfunction

endpackage : parity_pkg
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// ============================================================================
//  Module      : skid_buf2
//  Description : Generic 2-entry valid/grant skid buffer. The upstream grant
//                depends only on registered occupancy, so there is no
//                combinational path from the downstream grant to upstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module skid_buf2
   import parity_pkg::*;
#(
   parameter int WIDTH = 33
) (
   input  logic             clk,
   input  logic             rst_n,
   // upstream side
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_valid_i,
   output logic             in_grant_o,
   // downstream side
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_valid_o,
   input  logic             out_grant_i
);

   buf_state_e       state_q, state_d;
   logic [WIDTH-1:0] head_q, head_d;   // oldest held word, always on out_data_o
   logic [WIDTH-1:0] tail_q, tail_d;   // second word, only meaningful in ST_TWO
   logic             w_push;
   logic             w_pop;

   assign w_push = in_valid_i & in_grant_o;
   assign w_pop  = out_valid_o & out_grant_i;

   // State and storage registers; reset empties the buffer immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   // Next-state: occupancy follows the push/pop pair
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: begin
            if (w_push) state_d = ST_ONE;
         end
         ST_ONE: begin
            if (w_push && !w_pop)      state_d = ST_TWO;
            else if (!w_push && w_pop) state_d = ST_EMPTY;
         end
         ST_TWO: begin
            if (w_pop) state_d = ST_ONE;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // Storage update: head always holds the oldest word, tail the newer one
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      case (state_q)
         ST_EMPTY: begin
            if (w_push) head_d = in_data_i;
         end
         ST_ONE: begin
            // push together with pop replaces the head directly
            if (w_push && w_pop) head_d = in_data_i;
            else if (w_push)     tail_d = in_data_i;
         end
         ST_TWO: begin
            if (w_pop) head_d = tail_q;
         end
         default: begin
            head_d = head_q;
            tail_d = tail_q;
         end
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      in_grant_o  = (state_q != ST_TWO);
      out_valid_o = (state_q != ST_EMPTY);
      out_data_o  = head_q;
   end

endmodule : skid_buf2
`default_nettype wire

// File: rtl/parity_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module      : parity_gen_stage
//  Description : Appends a parity bit to each accepted payload, optionally
//                corrupting it on request, buffers up to two words toward a
//                FIFO push port and counts the words delivered.
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_gen_stage
   import parity_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int EVEN_ODD   = 0,   // 0: even parity, 1: odd parity
   parameter int PARITY_BIT = 0    // 0: parity at bit 0, 1: parity at MSB
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                 valid_i,
   output logic                 grant_o,
   output logic [DATA_WIDTH:0]  data_o,
   output logic                 valid_o,
   input  logic                 grant_i,
   input  logic                 corrupt_i,
   output logic [c_cnt_w-1:0]   word_cnt_o
);

   localparam int c_word_w = DATA_WIDTH + 1;

   logic                   w_accept;
   logic                   w_send;
   logic                   w_corrupt_now;
   logic                   w_par;
   logic [c_par_max_w-1:0] w_payload_ext;
   logic [c_word_w-1:0]    w_word;

   logic                   armed_q, armed_d;
   logic [c_cnt_w-1:0]     word_cnt_q, word_cnt_d;

   assign w_accept = valid_i & grant_o;
   assign w_send   = valid_o & grant_i;

   // A pulse at the same edge as an accept corrupts that very word
   assign w_corrupt_now = armed_q | corrupt_i;

   // Zero-extend the payload to the helper's fixed argument width
   always_comb begin
      w_payload_ext                 = '0;
      w_payload_ext[DATA_WIDTH-1:0] = data_i;
      w_par = calc_parity(w_payload_ext, (EVEN_ODD != 0), w_corrupt_now);
   end

   // Place the parity bit at the selected end of the stored word
   generate
      if (PARITY_BIT == 0) begin : g_par_lsb
         assign w_word = {data_i, w_par};
      end else begin : g_par_msb
         assign w_word = {w_par, data_i};
      end
   endgenerate

   // Corruption flag and delivered-word counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q    <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         armed_q    <= armed_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   // Arm on any pulse; the first accepted word consumes the arming. Several
   // pulses before an accept still only corrupt one word.
   always_comb begin
      armed_d    = armed_q;
      word_cnt_d = word_cnt_q;
      if (w_accept)       armed_d = 1'b0;
      else if (corrupt_i) armed_d = 1'b1;
      // natural modulo-2^16 wrap
      if (w_send) word_cnt_d = word_cnt_q + 1'b1;
   end

   assign word_cnt_o = word_cnt_q;

   skid_buf2 #(
      .WIDTH (c_word_w)
   ) u_skid_buf2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data_i   (w_word),
      .in_valid_i  (valid_i),
      .in_grant_o  (grant_o),
      .out_data_o  (data_o),
      .out_valid_o (valid_o),
      .out_grant_i (grant_i)
   );

endmodule : parity_gen_stage
`default_nettype wire

// File: tb/tb_parity_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parity_gen_stage
//  Description : Self-checking bench for parity_gen_stage. Two instances run
//                on the same stimulus: default (even, parity at LSB) and
//                odd parity with parity at MSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_gen_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] data_i;
   logic        valid_i;
   logic        grant_i;
   logic        corrupt_i;

   logic        grant0, valid0, grant1, valid1;
   logic [32:0] data0, data1;
   logic [15:0] cnt0, cnt1;

   int total = 0;
   int bad   = 0;

   // model state: each entry is {corrupt, payload}
   logic [32:0] mq[$];
   logic        armed;
   int          sent;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   parity_gen_stage #(.DATA_WIDTH(32), .EVEN_ODD(0), .PARITY_BIT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
      .grant_o(grant0), .data_o(data0), .valid_o(valid0), .grant_i(grant_i),
      .corrupt_i(corrupt_i), .word_cnt_o(cnt0)
   );

   parity_gen_stage #(.DATA_WIDTH(32), .EVEN_ODD(1), .PARITY_BIT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
      .grant_o(grant1), .data_o(data1), .valid_o(valid1), .grant_i(grant_i),
      .corrupt_i(corrupt_i), .word_cnt_o(cnt1)
   );

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected output word from the parity rule, independent of the RTL
   function automatic logic [32:0] exp_word(input logic [31:0] p, input logic c,
                                            input bit odd, input bit msb);
      logic par;
      par = (($countones(p) % 2) == 1) ^ odd ^ c;
      return msb ? {par, p} : {p, par};
   endfunction

   task automatic check_outputs();
      chk("grant0", {32'd0, grant0}, {32'd0, mq.size() < 2});
      chk("valid0", {32'd0, valid0}, {32'd0, mq.size() > 0});
      chk("grant1", {32'd0, grant1}, {32'd0, mq.size() < 2});
      chk("valid1", {32'd0, valid1}, {32'd0, mq.size() > 0});
      chk("cnt0", {17'd0, cnt0}, {17'd0, 16'(sent)});
      chk("cnt1", {17'd0, cnt1}, {17'd0, 16'(sent)});
      if (mq.size() > 0) begin
         chk("data0", data0, exp_word(mq[0][31:0], mq[0][32], 1'b0, 1'b0));
         chk("data1", data1, exp_word(mq[0][31:0], mq[0][32], 1'b1, 1'b1));
      end
   endtask

   // One clock: drive inputs, check at the falling edge, update the model
   // with the transfers at the rising edge, return 1 time unit after it.
   task automatic cycle(input logic v, input logic [31:0] d, input logic c, input logic g);
      logic        acc, snd, cor;
      logic [32:0] tmp;
      valid_i   = v;
      data_i    = d;
      corrupt_i = c;
      grant_i   = g;
      @(negedge clk);
      check_outputs();
      acc = v && (mq.size() < 2);
      snd = g && (mq.size() > 0);
      cor = acc && (armed || c);
      @(posedge clk);
      if (snd) begin
         tmp = mq.pop_front();
         sent++;
      end
      if (acc) mq.push_back({cor, d});
      armed = acc ? 1'b0 : (armed | c);
      #1;
   endtask

   task automatic model_reset();
      mq.delete();
      armed = 1'b0;
      sent  = 0;
   endtask

   initial begin
      rst_n     = 1'b0;
      data_i    = '0;
      valid_i   = 1'b0;
      grant_i   = 1'b0;
      corrupt_i = 1'b0;
      model_reset();
      #12;
      // reset state
      chk("rst_valid", {32'd0, valid0}, 33'd0);
      chk("rst_grant", {32'd0, grant0}, 33'd1);
      chk("rst_data",  data0, 33'd0);
      chk("rst_cnt",   {17'd0, cnt0}, 33'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // basic parity, one-cycle latency, first accept right after reset
      cycle(1'b1, 32'h3, 1'b0, 1'b1);
      chk("lat_data0", data0, 33'h006);
      chk("lat_valid0", {32'd0, valid0}, 33'd1);
      cycle(1'b1, 32'h7, 1'b0, 1'b1);
      chk("par7_data0", data0, 33'h00F);
      chk("par7_data1", data1, 33'h0_0000_0007);
      chk("cnt_one", {17'd0, cnt0}, 33'd1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);

      // corruption: two pulses arm one corruption
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      cycle(1'b1, 32'h3, 1'b0, 1'b1);
      chk("corr_data0", data0, 33'h007);
      cycle(1'b1, 32'h3, 1'b0, 1'b1);
      chk("corr_next0", data0, 33'h006);
      // pulse at the same edge as the accept
      cycle(1'b1, 32'h3, 1'b1, 1'b1);
      chk("corr_same0", data0, 33'h007);
      cycle(1'b1, 32'h3, 1'b0, 1'b1);
      chk("corr_after0", data0, 33'h006);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);

      // backpressure: two accepts fill the buffer, third word ignored
      cycle(1'b1, 32'h1, 1'b0, 1'b0);
      cycle(1'b1, 32'h2, 1'b0, 1'b0);
      chk("full_grant0", {32'd0, grant0}, 33'd0);
      cycle(1'b1, 32'h3, 1'b0, 1'b0);
      chk("full_head0", data0, 33'h003);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      chk("full_second0", data0, 33'h005);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      chk("full_drained", {32'd0, valid0}, 33'd0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), $urandom,
               1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
      end

      // asynchronous reset while holding two words
      cycle(1'b1, $urandom, 1'b1, 1'b0);
      cycle(1'b1, $urandom, 1'b0, 1'b0);
      chk("two_grant0", {32'd0, grant0}, 33'd0);
      valid_i = 1'b0;
      corrupt_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid0", {32'd0, valid0}, 33'd0);
      chk("arst_cnt0",   {17'd0, cnt0}, 33'd0);
      chk("arst_grant0", {32'd0, grant0}, 33'd1);
      chk("arst_data0",  data0, 33'd0);
      model_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);

      // the accept after reset must not carry the pre-reset arming
      cycle(1'b1, 32'h3, 1'b0, 1'b1);
      chk("arst_noarm0", data0, 33'h006);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1 model_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;

      // sustained throughput with counter wrap
      for (int i = 0; i < 70000; i++) begin
         cycle(1'b1, $urandom, 1'b0, 1'b1);
      end
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      chk("wrap_cnt0", {17'd0, cnt0}, 33'd4464);
      chk("wrap_cnt1", {17'd0, cnt1}, 33'd4464);
      chk("wrap_empty", {32'd0, valid0}, 33'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_parity_gen_stage
`default_nettype wire
